// File: rtl/as_eth_hdr_lookup_pkg.sv
// Shared constants and state types for the Ethernet header lookup front end.
package as_eth_hdr_lookup_pkg;

    // ctrl value that marks the IOQ module header word
    localparam logic [7:0] IOQ_STAGE_NUM_DFLT = 8'hFF;

    // IOQ header field positions and widths
    localparam int DST_PORT_POS = 48;
    localparam int SRC_PORT_POS = 16;
    localparam int DST_FIELD_W  = 16;

    // Input-side packet parser
    typedef enum logic [1:0] {
        P_HDR,
        P_W2,
        P_LOOK,
        P_EOP
    } parse_state_e;

    // Output-side forwarder
    typedef enum logic [1:0] {
        O_WAIT,
        O_PASS,
        O_DROP
    } out_state_e;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word-fall-through packet buffer: dout shows the head entry whenever empty=0.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = (cnt_q == CNT_W'(DEPTH));
    assign empty       = (cnt_q == '0);
    // Two free entries left covers a writer that reacts to in_rdy one cycle late.
    assign nearly_full = (cnt_q >= CNT_W'(DEPTH - 2));
    // A write into a full buffer is discarded; the nearly_full margin keeps this unreachable.
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem_q[rd_ptr_q];

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(do_wr);
        rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(do_rd);
        cnt_d    = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    // Pointer/count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/as_eth_hdr_lookup.sv
// Parses dst/src MAC and ingress port, issues one CAM lookup per packet, buffers the
// packet meanwhile and forwards it with the looked-up dst ports, or drops it on a zero result.
module as_eth_hdr_lookup
    import as_eth_hdr_lookup_pkg::*;
#(
    parameter int         DATA_WIDTH        = 64,
    parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int         NUM_OUTPUT_QUEUES = 8,
    parameter int         NUM_IQ_BITS       = 3,
    parameter logic [7:0] IOQ_STAGE_NUM     = IOQ_STAGE_NUM_DFLT,
    parameter int         FIFO_DEPTH_BITS   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,
    output logic [47:0]                  dst_mac,
    output logic [47:0]                  src_mac,
    output logic [NUM_IQ_BITS-1:0]       src_port,
    output logic                         lookup_req,
    input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    input  logic                         lookup_ack,
    output logic                         pkt_dropped
);

    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(IOQ_STAGE_NUM);

    // packet buffer
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic [CTRL_WIDTH-1:0]            f_ctrl;
    logic [DATA_WIDTH-1:0]            f_data;
    logic                             fifo_rd, fifo_empty, fifo_nf;

    // parse side
    parse_state_e                 p_state_q, p_state_d;
    logic [NUM_IQ_BITS-1:0]       src_port_q, src_port_d;
    logic [47:0]                  dst_mac_q, dst_mac_d;
    logic [47:0]                  src_mac_q, src_mac_d;
    logic                         req_q, req_d;
    logic                         need_q, need_d;   // lookup owed, waiting for old ack to clear
    logic                         got_q, got_d;     // result captured, not yet handed to output side
    logic [NUM_OUTPUT_QUEUES-1:0] pend_q, pend_d;
    logic                         eop_q, eop_d;     // EOP already accepted while in P_LOOK
    logic                         eop_now;
    logic                         in_eop;
    logic                         rdy_en_q;

    // result handoff
    logic [NUM_OUTPUT_QUEUES-1:0] res_q, res_d;
    logic                         res_vld_q, res_vld_d;
    logic                         res_clr;

    // output side
    out_state_e o_state_q, o_state_d;
    logic       o_pl_q, o_pl_d;                     // payload of the current packet has started
    logic       drop_q, drop_d;
    logic       f_eop;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nf),
        .empty       (fifo_empty)
    );

    assign f_ctrl      = fifo_dout[CTRL_WIDTH+DATA_WIDTH-1 -: CTRL_WIDTH];
    assign f_data      = fifo_dout[DATA_WIDTH-1:0];
    assign f_eop       = o_pl_q && (f_ctrl != '0);
    assign in_eop      = in_wr && (in_ctrl != '0);

    assign dst_mac     = dst_mac_q;
    assign src_mac     = src_mac_q;
    assign src_port    = src_port_q;
    assign lookup_req  = req_q;
    assign pkt_dropped = drop_q;

    // Input is held while a finished packet's result waits for the output side, so the
    // parser never sees the next packet's header before the current result is handed off.
    assign in_rdy = rdy_en_q && !fifo_nf &&
                    !((p_state_q == P_LOOK) && ((got_q && res_vld_q) || eop_q));

    // Output FSM: forward or discard one buffered packet per valid result
    always_comb begin
        o_state_d = o_state_q;
        o_pl_d    = o_pl_q;
        drop_d    = 1'b0;
        fifo_rd   = 1'b0;
        out_wr    = 1'b0;
        res_clr   = 1'b0;
        out_ctrl  = f_ctrl;
        out_data  = f_data;
        if (!o_pl_q && (f_ctrl == IOQ_CTRL))
            out_data[DST_PORT_POS +: DST_FIELD_W] = DST_FIELD_W'(res_q);
        case (o_state_q)
            O_WAIT: begin
                if (res_vld_q && !fifo_empty)
                    o_state_d = (res_q == '0) ? O_DROP : O_PASS;
            end
            O_PASS, O_DROP: begin
                if (!fifo_empty && (out_rdy || (o_state_q == O_DROP))) begin
                    fifo_rd = 1'b1;
                    out_wr  = (o_state_q == O_PASS);
                    if (f_ctrl == '0) o_pl_d = 1'b1;
                    if (f_eop) begin
                        o_pl_d    = 1'b0;
                        res_clr   = 1'b1;
                        drop_d    = (o_state_q == O_DROP);
                        o_state_d = O_WAIT;
                    end
                end
            end
            default: o_state_d = O_WAIT;
        endcase
    end

    // Parse FSM: extract lookup keys, run the req/ack handshake, hand the result over
    always_comb begin
        p_state_d  = p_state_q;
        src_port_d = src_port_q;
        dst_mac_d  = dst_mac_q;
        src_mac_d  = src_mac_q;
        req_d      = req_q;
        need_d     = need_q;
        got_d      = got_q;
        pend_d     = pend_q;
        eop_d      = eop_q;
        eop_now    = eop_q || in_eop;
        res_d      = res_q;
        res_vld_d  = res_vld_q && !res_clr;   // output-side clear first, set below wins
        case (p_state_q)
            P_HDR: begin
                if (in_wr) begin
                    if (in_ctrl == IOQ_CTRL) begin
                        src_port_d = in_data[SRC_PORT_POS +: NUM_IQ_BITS];
                    end else if (in_ctrl == '0) begin
                        dst_mac_d         = in_data[DATA_WIDTH-1 -: 48];
                        src_mac_d[47:32]  = in_data[DATA_WIDTH-49 -: 16];
                        p_state_d         = P_W2;
                    end
                end
            end
            P_W2: begin
                if (in_wr) begin
                    src_mac_d[31:0] = in_data[DATA_WIDTH-1 -: 32];
                    p_state_d       = P_LOOK;
                    if (in_eop) begin
                        // runt: no lookup, zero result drops it
                        got_d  = 1'b1;
                        pend_d = '0;
                        eop_d  = 1'b1;
                    end else begin
                        need_d = 1'b1;
                        eop_d  = 1'b0;
                    end
                end
            end
            P_LOOK: begin
                if (in_eop) eop_d = 1'b1;
                if (need_q && !lookup_ack) begin
                    req_d  = 1'b1;
                    need_d = 1'b0;
                end
                if (req_q && lookup_ack) begin
                    req_d  = 1'b0;
                    got_d  = 1'b1;
                    pend_d = dst_ports;
                end
                if (got_q && (!res_vld_q || res_clr)) begin
                    res_d     = pend_q;
                    res_vld_d = 1'b1;
                    got_d     = 1'b0;
                    eop_d     = 1'b0;
                    p_state_d = eop_now ? P_HDR : P_EOP;
                end
            end
            P_EOP: begin
                if (in_eop) p_state_d = P_HDR;
            end
            default: p_state_d = P_HDR;
        endcase
    end

    // State registers for both FSMs and the result handoff
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state_q  <= P_HDR;
            src_port_q <= '0;
            dst_mac_q  <= '0;
            src_mac_q  <= '0;
            req_q      <= 1'b0;
            need_q     <= 1'b0;
            got_q      <= 1'b0;
            pend_q     <= '0;
            eop_q      <= 1'b0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            o_state_q  <= O_WAIT;
            o_pl_q     <= 1'b0;
            drop_q     <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            p_state_q  <= p_state_d;
            src_port_q <= src_port_d;
            dst_mac_q  <= dst_mac_d;
            src_mac_q  <= src_mac_d;
            req_q      <= req_d;
            need_q     <= need_d;
            got_q      <= got_d;
            pend_q     <= pend_d;
            eop_q      <= eop_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
            o_state_q  <= o_state_d;
            o_pl_q     <= o_pl_d;
            drop_q     <= drop_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule
